// File: rtl/lsu_initiator_pkg.sv
// Shared ISA constants for the decoder, the ALU and the load/store initiator.
package lsu_initiator_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_R    = 6'b000000;

    // Instruction field positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/lsu_queue.sv
// Request FIFO: two pushes per cycle (slot A lands before slot B), one pop,
// occupancy counter to tell full from empty, and a look-ahead read of the
// entry behind the head so the issuer can re-issue straight after an ack.
module lsu_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_a,
    input  logic [W-1:0]             din_a,
    input  logic                     push_b,
    input  logic [W-1:0]             din_b,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [W-1:0]             next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     free2,
    output logic                     has_next,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] head_nx;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] tail_b;
    logic          pop_ok;

    assign pop_ok   = pop & ~empty;
    assign tail_b   = tail_ptr + PW'(push_a);
    assign head_nx  = head_ptr + PW'(1);
    assign head     = mem[head_ptr];
    assign next     = mem[head_nx];
    assign empty    = (count == '0);
    assign has_next = (count >= CW'(2));
    assign free2    = (count <= CW'(DEPTH - 2));

    // Storage write: slot B goes behind slot A when both push
    always_ff @(posedge clk) begin
        if (push_a) mem[tail_ptr] <= din_a;
        if (push_b) mem[tail_b]   <= din_b;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks pushes - pop
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(pop_ok);
            tail_ptr <= tail_ptr + PW'(push_a) + PW'(push_b);
            count    <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: decodes lw/sw from two issue slots, queues them in
// program order and issues them one at a time on a valid/ack memory port.
// Load results come back as a single-cycle register write strobe.
module lsu_initiator
    import lsu_initiator_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   ins_a,
    input  logic [31:0]   base_a,
    input  logic [31:0]   wdata_a,
    input  logic          valid_a,
    input  logic [31:0]   ins_b,
    input  logic [31:0]   base_b,
    input  logic [31:0]   wdata_b,
    input  logic          valid_b,
    output logic          in_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [4:0]    wb_addr,
    output logic [31:0]   wb_data,
    output logic          wb_valid,
    output logic          busy
);

    // Entry layout: {we, addr, wdata, rt}
    localparam int EW = 1 + AW + 32 + 5;
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [5:0]    op_a, op_b;
    logic          mem_a, mem_b;
    logic          push_a, push_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [EW-1:0] ent_a, ent_b, ent_first;
    logic [EW-1:0] q_head, q_next;
    logic [CW-1:0] q_count;
    logic          q_free2, q_has_next, q_empty;
    logic          ack_fire;
    lsu_state_e    state;
    logic          unused_rs;

    assign op_a   = ins_a[OP_HI:OP_LO];
    assign op_b   = ins_b[OP_HI:OP_LO];
    assign mem_a  = valid_a & is_mem_op(op_a);
    assign mem_b  = valid_b & is_mem_op(op_b);
    assign push_a = in_ready & mem_a;
    assign push_b = in_ready & mem_b;

    // Effective address is formed once, at enqueue
    assign addr_a = AW'(base_a + sext16(ins_a[IMM_HI:IMM_LO]));
    assign addr_b = AW'(base_b + sext16(ins_b[IMM_HI:IMM_LO]));
    assign ent_a  = {op_a == OP_SW, addr_a, wdata_a, ins_a[RT_HI:RT_LO]};
    assign ent_b  = {op_b == OP_SW, addr_b, wdata_b, ins_b[RT_HI:RT_LO]};

    // Oldest entry accepted this cycle, used to issue straight out of an empty queue
    assign ent_first = push_a ? ent_a : ent_b;

    // rs field only matters upstream (operand read)
    assign unused_rs = ^{ins_a[RS_HI:RS_LO], ins_b[RS_HI:RS_LO]};

    assign in_ready = q_free2;
    assign busy     = (q_count != '0) | mem_req;
    assign ack_fire = (state == ST_REQ) & mem_req & mem_ack;

    lsu_queue #(
        .DEPTH (QDEPTH),
        .W     (EW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push_a   (push_a),
        .din_a    (ent_a),
        .push_b   (push_b),
        .din_b    (ent_b),
        .pop      (ack_fire),
        .head     (q_head),
        .next     (q_next),
        .count    (q_count),
        .free2    (q_free2),
        .has_next (q_has_next),
        .empty    (q_empty)
    );

    // Issue FSM: the head stays queued while outstanding and is popped on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        mem_we    <= q_head[EW-1];
                        mem_addr  <= q_head[EW-2 -: AW];
                        mem_wdata <= q_head[36:5];
                        mem_req   <= 1'b1;
                        state     <= ST_REQ;
                    end else if (push_a | push_b) begin
                        mem_we    <= ent_first[EW-1];
                        mem_addr  <= ent_first[EW-2 -: AW];
                        mem_wdata <= ent_first[36:5];
                        mem_req   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_fire) begin
                        if (!q_head[EW-1]) begin
                            wb_addr  <= q_head[4:0];
                            wb_data  <= mem_rdata;
                            wb_valid <= (q_head[4:0] != 5'd0);
                        end
                        if (q_has_next) begin
                            mem_we    <= q_next[EW-1];
                            mem_addr  <= q_next[EW-2 -: AW];
                            mem_wdata <= q_next[36:5];
                        end else begin
                            mem_req <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Directed bench for lsu_initiator: a cycle table for the basic load/store
// flows, then hand-written sequences for queue fill, reset and wrap.
module tb_lsu_initiator;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_a, base_a, wdata_a, ins_b, base_b, wdata_b;
    logic        valid_a, valid_b;
    logic        in_ready, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_valid, busy;

    int checks = 0;
    int errors = 0;

    logic [36:0] got[$];
    logic [36:0] exp_wb[$];

    lsu_initiator #(.QDEPTH(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .ins_a(ins_a), .base_a(base_a), .wdata_a(wdata_a), .valid_a(valid_a),
        .ins_b(ins_b), .base_b(base_b), .wdata_b(wdata_b), .valid_b(valid_b),
        .in_ready(in_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_valid(wb_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Writeback monitor: one record per strobe
    always @(negedge clk) if (wb_valid) got.push_back({wb_addr, wb_data});

    typedef struct {
        logic        va;  logic [31:0] ia; logic [31:0] ba; logic [31:0] wa;
        logic        vb;  logic [31:0] ib; logic [31:0] bb; logic [31:0] wb;
        logic        ack; logic [31:0] rdata;
        logic        rdy; logic req; logic we; logic [31:0] addr; logic [31:0] wdata;
        logic        wbv; logic [4:0] wba; logic [31:0] wbd; logic bsy;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {op, 5'd0, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slots(input logic va, input logic [31:0] ia, input logic [31:0] ba,
                         input logic vb, input logic [31:0] ib, input logic [31:0] bb);
        valid_a = va; ins_a = ia; base_a = ba; wdata_a = 32'h0;
        valid_b = vb; ins_b = ib; base_b = bb; wdata_b = 32'h0;
    endtask

    task automatic idle();
        slots(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        slots(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b1; mem_rdata = d;
    endtask

    task automatic cmp_wb(input string nm);
        chk({nm, " wb count"}, got.size(), exp_wb.size());
        for (int i = 0; i < exp_wb.size() && i < got.size(); i++)
            chk($sformatf("%s wb[%0d]", nm, i), {27'd0, got[i][36:32]} ^ got[i][31:0] ^ 32'h0,
                {27'd0, exp_wb[i][36:32]} ^ exp_wb[i][31:0]);
        for (int i = 0; i < exp_wb.size() && i < got.size(); i++)
            chk($sformatf("%s wb_addr[%0d]", nm, i), got[i][36:32], exp_wb[i][36:32]);
    endtask

    initial begin
        rst = 1'b1; mem_rdata = 32'h0;
        idle();

        tbl[0]  = '{1, mk(LW, 8, 16'hFFFC), 32'h10, 32'h0, 0, 0, 0, 0, 0, 0,
                    1, 1, 0, 32'h0C, 32'h0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 1, 0, 32'h0C, 32'h0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                    1, 0, 0, 0, 0, 1, 8, 32'hDEADBEEF, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, mk(SW, 3, 16'h0020), 32'h0, 32'h55, 1, mk(LW, 9, 16'h0010), 32'h10, 32'h77,
                    0, 0, 1, 1, 1, 32'h20, 32'h55, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678,
                    1, 1, 0, 32'h20, 32'h77, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,
                    1, 0, 0, 0, 0, 1, 9, 32'hCAFEF00D, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, mk(LW, 0, 16'h0004), 32'h100, 32'hAA, 1, mk(ADDI, 5, 16'h0001), 32'h7, 32'h1,
                    0, 0, 1, 1, 0, 32'h104, 32'hAA, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h999,
                    1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555,
                    1, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        cyc(); cyc();
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_addr", wb_addr, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        cyc();
        chk("rst in_ready", in_ready, 1);

        // Table-driven cycles
        for (int i = 0; i < 11; i++) begin
            valid_a = tbl[i].va; ins_a = tbl[i].ia; base_a = tbl[i].ba; wdata_a = tbl[i].wa;
            valid_b = tbl[i].vb; ins_b = tbl[i].ib; base_b = tbl[i].bb; wdata_b = tbl[i].wb;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
            cyc();
            chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("v%0d mem_req", i), mem_req, tbl[i].req);
            chk($sformatf("v%0d busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d wb_valid", i), wb_valid, tbl[i].wbv);
            if (tbl[i].req) begin
                chk($sformatf("v%0d mem_we", i), mem_we, tbl[i].we);
                chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].addr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].wdata);
            end
            if (tbl[i].wbv) begin
                chk($sformatf("v%0d wb_addr", i), wb_addr, tbl[i].wba);
                chk($sformatf("v%0d wb_data", i), wb_data, tbl[i].wbd);
            end
        end
        idle(); cyc();

        // Fill the queue with four loads while no ack is given
        got.delete(); exp_wb.delete();
        slots(1, mk(LW, 1, 16'h0040), 0, 0, 0, 0); cyc();
        chk("fill req", mem_req, 1);
        chk("fill addr0", mem_addr, 32'h40);
        chk("fill rdy1", in_ready, 1);
        slots(1, mk(LW, 2, 16'h0041), 0, 0, 0, 0); cyc();
        chk("fill rdy2", in_ready, 1);
        slots(1, mk(LW, 3, 16'h0042), 0, 1, mk(LW, 4, 16'h0043), 0); cyc();
        chk("fill rdy4", in_ready, 0);
        slots(1, mk(LW, 20, 16'h0050), 0, 1, mk(LW, 21, 16'h0051), 0); cyc();
        chk("fill ignored rdy", in_ready, 0);
        chk("fill held addr", mem_addr, 32'h40);
        ack(32'h1001); cyc();
        chk("fill rdy at 3", in_ready, 0);
        chk("fill addr1", mem_addr, 32'h41);
        chk("fill req1", mem_req, 1);
        ack(32'h1002); cyc();
        chk("fill rdy at 2", in_ready, 1);
        chk("fill addr2", mem_addr, 32'h42);
        ack(32'h1003); cyc();
        chk("fill addr3", mem_addr, 32'h43);
        ack(32'h1004); cyc();
        chk("fill drained req", mem_req, 0);
        chk("fill drained busy", busy, 0);
        idle(); cyc();
        for (int i = 1; i <= 4; i++) exp_wb.push_back({5'(i), 32'h1000 + 32'(i)});
        cmp_wb("fill");

        // Reset while a request is outstanding, then a late ack
        got.delete(); exp_wb.delete();
        slots(1, mk(LW, 7, 16'h0060), 0, 0, 0, 0); cyc();
        chk("rstmid req before", mem_req, 1);
        idle(); rst = 1'b1; cyc();
        chk("rstmid req", mem_req, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid in_ready", in_ready, 1);
        chk("rstmid wb_valid", wb_valid, 0);
        rst = 1'b0; ack(32'h777); cyc();
        chk("late ack req", mem_req, 0);
        chk("late ack wb_valid", wb_valid, 0);
        chk("late ack busy", busy, 0);
        idle(); cyc();
        chk("late ack no wb", got.size(), 0);

        // Mixed traffic with random ack delays; queue pointers wrap several times
        got.delete(); exp_wb.delete();
        begin
            localparam int N = 24;
            logic [31:0] ins_l[N];
            logic [31:0] base_l[N];
            int acks = 0;
            for (int i = 0; i < N; i++) begin
                logic [15:0] imm;
                logic [31:0] addr;
                imm  = 16'(i * 3) - 16'd8;
                addr = 32'h200 + 32'(i);
                base_l[i] = addr - {{16{imm[15]}}, imm};
                if (i % 5 == 3) ins_l[i] = mk(SW, 5'(i), imm);
                else begin
                    ins_l[i] = mk(LW, 5'((i % 31) + 1), imm);
                    exp_wb.push_back({5'((i % 31) + 1), addr ^ KEY});
                end
            end
            fork
                begin : producer
                    int idx = 0;
                    int cyc_p = 0;
                    while (idx < N && cyc_p < 3000) begin
                        cyc(); cyc_p++;
                        valid_a = 0; valid_b = 0;
                        if (in_ready) begin
                            valid_a = 1; ins_a = ins_l[idx]; base_a = base_l[idx];
                            wdata_a = 32'(idx); idx++;
                            if (idx < N && $urandom_range(0, 1) == 1) begin
                                valid_b = 1; ins_b = ins_l[idx]; base_b = base_l[idx];
                                wdata_b = 32'(idx); idx++;
                            end
                        end
                    end
                    cyc(); valid_a = 0; valid_b = 0;
                    if (idx < N) chk("wrap producer timeout", 32'(idx), 32'(N));
                end
                begin : responder
                    int wait_left = -1;
                    int cyc_r = 0;
                    while (acks < N && cyc_r < 3000) begin
                        cyc(); cyc_r++;
                        if (mem_ack) begin
                            acks++;
                            wait_left = -1;
                        end
                        mem_ack = 0;
                        if (mem_req && acks < N) begin
                            if (wait_left < 0) wait_left = $urandom_range(0, 3);
                            if (wait_left == 0) begin
                                mem_ack = 1; mem_rdata = mem_addr ^ KEY;
                            end else wait_left--;
                        end
                    end
                    mem_ack = 0;
                    if (acks < N) chk("wrap responder timeout", 32'(acks), 32'(N));
                end
            join
        end
        idle();
        repeat (4) cyc();
        chk("wrap idle busy", busy, 0);
        cmp_wb("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
Load/store initiator that drives the data-memory responder's request interface.
- Accepts decoded lw/sw instructions from the two issue slots, with operands already read from regs.
- Queues them in program order and issues them one at a time over a valid/ack memory handshake.
- Returns load results as a single register write port (addr, data, valid) into regs.

Parameters:
QDEPTH, 4, request queue entries (power of two, >=2)
AW, 32, memory word-address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ins_a  input  32  slot A instruction (older)
base_a  input  32  slot A rs value
wdata_a  input  32  slot A rt value (store data)
valid_a  input  1  slot A valid
ins_b  input  32  slot B instruction (younger)
base_b  input  32  slot B rs value
wdata_b  input  32  slot B rt value
valid_b  input  1  slot B valid
in_ready  output  1  queue can take two instructions this cycle
mem_req  output  1  memory request valid
mem_we  output  1  1 = store, 0 = load
mem_addr  output  AW  word address
mem_wdata  output  32  store data
mem_ack  input  1  responder completes the current request
mem_rdata  input  32  load data, valid with mem_ack
wb_addr  output  5  load destination register
wb_data  output  32  load result
wb_valid  output  1  write-back strobe, one cycle
busy  output  1  queue non-empty or request outstanding

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_addr=0, wb_data=0, busy=0. Queue is emptied; in_ready=1 from the first cycle after reset.
- Opcode decode uses ins[31:26]:
  - 6'b100011 is lw. 6'b101011 is sw.
  - Any other opcode is dropped silently and takes no queue entry.
- Address = base + sign-extend(ins[15:0]), modulo 2^AW. It is computed at enqueue.
- Queue entry holds {we, addr, wdata, rt=ins[20:16]}.
- in_ready = (free entries >= 2), computed combinationally from registered occupancy.
  - Valid slots presented while in_ready=0 are ignored. The upstream must hold them.
- Enqueue: with in_ready=1 on a clock edge, memory-op slot A is written first, then memory-op slot B. 0, 1 or 2 entries are added per cycle.
- FSM states:
  - IDLE: if the queue is non-empty, load the head into the output registers, assert mem_req next cycle, and go to REQ.
  - REQ: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack=1. On the ack edge, pop the head.
    - If another entry is present, re-issue directly: mem_req stays 1 with the new fields from the next cycle, and the state stays REQ.
    - Otherwise mem_req goes to 0 and the state returns to IDLE.
- Latency: enqueue in cycle N into an empty queue gives mem_req=1 in cycle N+1. An ack in cycle M gives wb_valid in cycle M+1. The minimum load-to-writeback time is 2 cycles after enqueue.
- Load completion: on ack of a load, register wb_addr=rt and wb_data=mem_rdata. Pulse wb_valid=1 for exactly one cycle.
  - If rt==0, wb_valid stays 0.
- Store completion: the ack retires the entry. wb_valid stays 0.
- mem_ack while mem_req=0 is ignored.
- Simultaneous enqueue and pop in one cycle are both honoured. Occupancy updates by (pushes − pop).
- Pointer wrap: head and tail wrap modulo QDEPTH. Full and empty are distinguished by an occupancy counter, 0..QDEPTH.
- busy = (occupancy != 0) | mem_req.
- rst mid-request: mem_req drops to 0 on that edge, the outstanding request is abandoned, and a late mem_ack after reset is ignored.

Decomposition:
- Shared package holds the opcode constants (OP_LW=6'b100011, OP_SW=6'b101011, OP_ADDI, OP_BEQ, OP_JAL, OP_R) and the instruction field positions (RS 25:21, RT 20:16, RD 15:11, IMM 15:0). These constants are shared with the decoder and the ALU.
- One sub-module: lsu_queue, a synchronous FIFO with dual push (push_a, push_b), single pop, occupancy count, and a free>=2 flag.

Test Plan:
- lw with rs=base_a=0x10, imm=0xFFFC, rt=8; ack with rdata=0xDEADBEEF after 2 cycles -> mem_addr=0x0C, mem_we=0; wb_valid pulses once with wb_addr=8, wb_data=0xDEADBEEF.
- Same cycle, slot A sw (addr 0x20, wdata 0x55) and slot B lw (addr 0x20, rt=9); ack each immediately -> store issued first, then the load is issued back-to-back with no IDLE gap; wb_addr=9.
- Fill the queue with QDEPTH loads while holding mem_ack=0 -> in_ready falls to 0 at occupancy QDEPTH−1; extra valid slots are not enqueued; after the acks, all QDEPTH writebacks appear in order.
- lw with rt=0, plus a non-memory opcode (addi) in slot B -> request issued, wb_valid stays 0, occupancy increments by 1 only.
- Assert rst for one cycle while mem_req=1, then pulse mem_ack -> mem_req=0 after the edge, busy=0, in_ready=1, no wb_valid.
- 20+ enqueue/ack cycles with random ack delays 0–3 -> pointers wrap correctly and writeback order matches enqueue order.
